// File: rtl/iram_1r1w1ck_param_if.sv
// Bundle for the simple dual-port RAM: write port, read port and read/init status.
// Master drives requests; slave returns read data, a valid pulse and init_done.
interface iram_1r1w1ck_param_if #(
    parameter int LANE_W = 173,
    parameter int LANES  = 3,
    parameter int AW     = 6
);
    localparam int WIDTH = LANES * LANE_W;

    logic             ena;
    logic [LANES-1:0] wea;
    logic [AW-1:0]    addra;
    logic [WIDTH-1:0] dia;
    logic             enb;
    logic [AW-1:0]    addrb;
    logic [WIDTH-1:0] dob;
    logic             dob_v;
    logic             init_done;

    modport master (
        output ena, wea, addra, dia, enb, addrb,
        input  dob, dob_v, init_done
    );

    modport slave (
        input  ena, wea, addra, dia, enb, addrb,
        output dob, dob_v, init_done
    );
endinterface

// File: rtl/iram_1r1w1ck_param.sv
// 1R1W single-clock RAM with lane write enables, optional zero-init and output register.
// Read latency 1 (OUT_REG=0) or 2 (OUT_REG=1); no backpressure, dob must be taken on dob_v.
module iram_1r1w1ck_param #(
    parameter int LANE_W    = 173,
    parameter int LANES     = 3,
    parameter int DEPTH     = 64,
    parameter int AW        = 6,
    parameter int OUT_REG   = 0,
    parameter int BYPASS    = 0,
    parameter int INIT_ZERO = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    iram_1r1w1ck_param_if.slave  bus
);
    localparam int              WIDTH   = LANES * LANE_W;
    localparam logic [AW:0]     DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW-1:0]   LAST_A  = AW'(DEPTH - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_INIT, ST_READY} state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic             init_done_q, init_done_d;

    logic [WIDTH-1:0] ram [DEPTH];
    logic [LANES-1:0] ram_we;
    logic [AW-1:0]    ram_wa;
    logic [WIDTH-1:0] ram_wd;

    logic             wr_ok;
    logic             rd_acc;
    logic             rd_in_range;
    logic             collide;
    logic [WIDTH-1:0] rd_word;

    logic             s1_vld_q, s1_vld_d;
    logic [WIDTH-1:0] s1_dat_q, s1_dat_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d   = '0;
                state_d = (INIT_ZERO != 0) ? ST_INIT : ST_READY;
            end
            ST_INIT: begin
                if (cnt_q == LAST_A) begin
                    state_d = ST_READY;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_READY: begin
                state_d = ST_READY;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        init_done_d = (state_d == ST_READY);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
        end
    end

    // The zeroing sequencer owns the write port until init_done; user writes are ignored.
    always_comb begin
        wr_ok  = init_done_q & bus.ena & ({1'b0, bus.addra} < DEPTH_W);
        ram_we = '0;
        ram_wa = bus.addra;
        ram_wd = bus.dia;
        if (state_q == ST_INIT) begin
            ram_we = '1;
            ram_wa = cnt_q;
            ram_wd = '0;
        end else if (wr_ok) begin
            ram_we = bus.wea;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (ram_we[i]) begin
                ram[ram_wa][i*LANE_W +: LANE_W] <= ram_wd[i*LANE_W +: LANE_W];
            end
        end
    end

    // The array read sees pre-edge contents, so a colliding read returns old data unless bypassed.
    always_comb begin
        rd_acc      = init_done_q & bus.enb;
        rd_in_range = ({1'b0, bus.addrb} < DEPTH_W);
        collide     = wr_ok & (bus.addra == bus.addrb);
        rd_word     = rd_in_range ? ram[bus.addrb] : '0;
        if ((BYPASS != 0) && collide) begin
            for (int i = 0; i < LANES; i++) begin
                if (bus.wea[i]) begin
                    rd_word[i*LANE_W +: LANE_W] = bus.dia[i*LANE_W +: LANE_W];
                end
            end
        end
        s1_vld_d = rd_acc;
        s1_dat_d = rd_acc ? rd_word : s1_dat_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_vld_q <= 1'b0;
            s1_dat_q <= '0;
        end else begin
            s1_vld_q <= s1_vld_d;
            s1_dat_q <= s1_dat_d;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic             s2_vld_q, s2_vld_d;
            logic [WIDTH-1:0] s2_dat_q, s2_dat_d;

            always_comb begin
                s2_vld_d = s1_vld_q;
                s2_dat_d = s1_vld_q ? s1_dat_q : s2_dat_q;
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    s2_vld_q <= 1'b0;
                    s2_dat_q <= '0;
                end else begin
                    s2_vld_q <= s2_vld_d;
                    s2_dat_q <= s2_dat_d;
                end
            end

            assign bus.dob   = s2_dat_q;
            assign bus.dob_v = s2_vld_q;
        end else begin : g_noreg
            assign bus.dob   = s1_dat_q;
            assign bus.dob_v = s1_vld_q;
        end
    endgenerate

    assign bus.init_done = init_done_q;

endmodule

// File: doc/iram_1r1w1ck_param.md
Name: iram_1r1w1ck_param

Overview:
Parametrised simple dual-port RAM with one write port, one read port and one clock, intended for Xilinx BRAM inference. It generalises the fixed 64x519 buffer with per-lane write enables, an optional output register stage and a read-valid pipeline. It also adds selectable read-during-write collision behaviour and an optional post-reset zero-initialisation sequencer. It is used as the storage element behind the TL/DL receive and replay buffers.

Parameters:
LANE_W, 173, width of one write-enable lane in bits
LANES, 3, number of write lanes; total data width WIDTH = LANES*LANE_W (default 519)
DEPTH, 64, number of entries; need not be a power of two
AW, 6, address width; must satisfy 2**AW >= DEPTH
OUT_REG, 0, 0: read latency 1; 1: extra output register, read latency 2
BYPASS, 0, 0: a same-cycle collision returns old data; 1: it returns new data per written lane
INIT_ZERO, 0, 1: after reset release, write zero to every entry before accepting traffic

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
ena  input  1  write port enable
wea  input  LANES  per-lane write enable, qualified by ena
addra  input  AW  write address
dia  input  WIDTH  write data; lane i is dia[i*LANE_W +: LANE_W]
enb  input  1  read enable
addrb  input  AW  read address
dob  output  WIDTH  read data
dob_v  output  1  one-cycle pulse marking dob as valid for a new read
init_done  output  1  high once the RAM accepts reads and writes

Behaviour:
- Reset: asynchronous, active-high. While reset is asserted, dob=0, dob_v=0, init_done=0, the init FSM returns to IDLE and the init counter clears. RAM contents are not reset.
- FSM states: IDLE -> INIT (INIT_ZERO=1) or IDLE -> READY (INIT_ZERO=0) on the first clk after reset deasserts.
- INIT state:
  - Writes all-zero to address cnt, cnt = 0..DEPTH-1, one entry per cycle.
  - Moves to READY after the cycle that writes DEPTH-1, so INIT lasts exactly DEPTH cycles.
- READY: init_done=1, registered; it stays 1 until the next reset.
- Until init_done=1, ena and enb are ignored: no user writes, no reads, dob_v stays 0.
- Reset asserted mid-INIT aborts the sequence. After release, INIT restarts from address 0.
- Write: when init_done, ena=1 and addra<DEPTH, each lane i with wea[i]=1 is updated at the clk edge. Lanes with wea[i]=0 are unchanged. Writes to addra>=DEPTH are dropped.
- Read:
  - When init_done, enb=1 is accepted.
  - Stage 1 registers the RAM word (or 0 if addrb>=DEPTH).
  - OUT_REG=0: dob and dob_v are valid 1 cycle after enb.
  - OUT_REG=1: stage 1 feeds a second register; dob and dob_v are valid 2 cycles after enb.
  - Back-to-back reads are fully pipelined, one per cycle.
- dob holds its last value when no new read completes. dob_v is 1 only in the cycle a new read result appears.
- Collision: enb and ena in the same cycle with addra==addrb (<DEPTH).
  - BYPASS=0: returned data is the pre-write contents.
  - BYPASS=1: lanes with wea[i]=1 return dia lane i; the other lanes return the old contents.
  - A write in any cycle after the read is accepted never affects that read's data.
- The output register stage has no enable stall. There is no backpressure; the consumer must take dob when dob_v=1.

Test Plan:
- INIT_ZERO=1, DEPTH=64: release reset -> init_done rises exactly 65 clks after release (1 IDLE + 64 INIT); a read of addr 63 returns 0 with dob_v one cycle later.
- INIT_ZERO=1: assert reset at INIT count 20, release -> init_done=0 throughout, INIT restarts at 0, and init_done rises 65 clks after the second release.
- OUT_REG=0 then OUT_REG=1: write addr 5 = pattern A, then read addr 5 -> dob=A with dob_v pulsing 1 (resp. 2) cycles after enb; dob holds A afterwards with dob_v=0.
- Lane enables: write all-ones to addr 7, then write zero with wea=3'b010 -> a read returns lanes 0 and 2 all-ones and lane 1 zero.
- Collision: preload addr 9 = X, then write Y to addr 9 with wea=3'b101 in the same cycle as a read of addr 9.
  - BYPASS=0 -> dob=X.
  - BYPASS=1 -> dob = {Y lane2, X lane1, Y lane0}.
  - A following read returns Y in lanes 0 and 2, X in lane 1.
- DEPTH=48, AW=6: write to addr 50 is dropped; a read of addr 50 returns 0 with dob_v=1; addr 47 reads back correctly; 100 back-to-back reads give 100 dob_v pulses in order.
